// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data-memory access unit.
//
// Consumes the EXE/MEM pipeline register outputs and performs word loads and
// stores against an internal RAM with a fixed multi-cycle latency. While an
// access is in flight the front of the pipeline is stalled. Branch resolution
// (PCSrc) is produced combinationally.
//
// Ports:
//   clk          clock, all state updates on posedge
//   rst          synchronous active-high reset
//   M_In[2:0]    {Branch, MemRead, MemWrite}
//   zeroIn       ALU zero flag
//   ALUResIn     byte address
//   readData2In  store data
//   readDataOut  registered load result
//   memDone      one-cycle completion pulse (registered)
//   memErr       registered; last request was misaligned or illegal
//   stall        combinational pipeline freeze
//   PCSrc        combinational branch-taken
//
// Optional feature (macro MEM_ACCESS_STATS_EN): adds rdCount, wrCount and
// stallCount 32-bit statistics outputs.
module mem_access_unit #(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned LATENCY     = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  M_In,
   input  logic        zeroIn,
   input  logic [31:0] ALUResIn,
   input  logic [31:0] readData2In,
   output logic [31:0] readDataOut,
   output logic        memDone,
   output logic        memErr,
   output logic        stall,
   output logic        PCSrc
`ifdef MEM_ACCESS_STATS_EN
   ,
   output logic [31:0] rdCount,
   output logic [31:0] wrCount,
   output logic [31:0] stallCount
`endif
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

   state_e          state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic [AW-1:0]   idx_q;
   logic [31:0]     wdata_q;
   logic            op_wr_q;

   logic [31:0]     mem [DEPTH_WORDS];

   logic            req;
   logic            illegal;
   logic            accept;
   logic            commit;
   logic            err_set;

   // Upper address bits are deliberately ignored: addresses wrap modulo the RAM.
   logic            unused_addr;
   assign unused_addr = ^ALUResIn[31:AW+2];

   assign req     = M_In[1] | M_In[0];
   assign illegal = (ALUResIn[1:0] != 2'b00) | (M_In[1] & M_In[0]);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      stall   = 1'b0;
      accept  = 1'b0;
      commit  = 1'b0;
      err_set = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (req) begin
               if (illegal) begin
                  err_set = 1'b1;
               end else begin
                  stall   = 1'b1;
                  accept  = 1'b1;
                  cnt_d   = 4'(LATENCY - 1);
                  state_d = StBusy;
               end
            end
         end
         StBusy: begin
            stall = 1'b1;
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               commit  = 1'b1;
               state_d = StResp;
            end
         end
         StResp: begin
            // EXE/MEM still presents the served instruction; ignore it.
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Branch outcome is suppressed only while the pipeline is frozen.
   assign PCSrc = M_In[2] & zeroIn & ~stall;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         cnt_q       <= 4'd0;
         idx_q       <= '0;
         wdata_q     <= 32'd0;
         op_wr_q     <= 1'b0;
         readDataOut <= 32'd0;
         memDone     <= 1'b0;
         memErr      <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         memDone <= commit | err_set;
         if (err_set) begin
            memErr <= 1'b1;
         end else if (accept) begin
            memErr <= 1'b0;
         end
         if (accept) begin
            idx_q   <= ALUResIn[AW+1:2];
            wdata_q <= readData2In;
            op_wr_q <= M_In[0];
         end
         if (commit && !op_wr_q) begin
            readDataOut <= mem[idx_q];
         end
      end
   end

   // RAM is never cleared; a reset in the commit cycle drops the write.
   always_ff @(posedge clk) begin
      if (!rst && commit && op_wr_q) begin
         mem[idx_q] <= wdata_q;
      end
   end

`ifdef MEM_ACCESS_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         rdCount    <= 32'd0;
         wrCount    <= 32'd0;
         stallCount <= 32'd0;
      end else begin
         if (commit && !op_wr_q) begin
            rdCount <= rdCount + 32'd1;
         end
         if (commit && op_wr_q) begin
            wrCount <= wrCount + 32'd1;
         end
         if (stall) begin
            stallCount <= stallCount + 32'd1;
         end
      end
   end
`endif

endmodule
